// File: rtl/fabric_arb_pkg.sv
// Shared types and bank-select constants for the fabric SRAM arbiter.
package fabric_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'b00,
        ARB_STREAM = 2'b01,
        ARB_DRAIN  = 2'b10
    } arb_state_t;

    localparam logic [1:0] BANK_A  = 2'b01;
    localparam logic [1:0] BANK_B  = 2'b10;
    localparam logic [1:0] BANK_AB = 2'b11;

    function automatic logic bank_hits_a(input logic [1:0] bank);
        return (bank & BANK_A) != 2'b00;
    endfunction

    function automatic logic bank_hits_b(input logic [1:0] bank);
        return (bank & BANK_B) != 2'b00;
    endfunction

endpackage

// File: rtl/fabric_stat_counter.sv
// Free-running statistics counter: increments when enabled, wraps at 2^CNT_W.
module fabric_stat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    // Count enabled cycles; natural overflow provides the wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= {CNT_W{1'b0}};
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fabric_sram_arbiter.sv
// Arbitrates the dual-bank ternary SRAM between engine reads and host writes.
// Optional statistics counters are built when ARB_STATS_EN is defined.
module fabric_sram_arbiter
    import fabric_arb_pkg::*;
#(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 24,
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              frame_active,
    input  logic              eng_req_valid,
    output logic              eng_req_ready,
    input  logic [ADDR_W-1:0] eng_req_addr,
    output logic              eng_rsp_valid,
    output logic [DATA_W-1:0] eng_rsp_weight,
    output logic [DATA_W-1:0] eng_rsp_input,
    input  logic              host_wr_valid,
    output logic              host_wr_ready,
    input  logic [ADDR_W-1:0] host_wr_addr,
    input  logic [1:0]        host_wr_bank,
    input  logic [DATA_W-1:0] host_wr_data,
    output logic [ADDR_W-1:0] sram_addr_a,
    output logic [ADDR_W-1:0] sram_addr_b,
    output logic              sram_we_a,
    output logic              sram_we_b,
    output logic [DATA_W-1:0] sram_din_a,
    output logic [DATA_W-1:0] sram_din_b,
    input  logic [DATA_W-1:0] sram_dout_a,
    input  logic [DATA_W-1:0] sram_dout_b,
    output logic [CNT_W-1:0]  stat_conflicts,
    output logic [CNT_W-1:0]  stat_forced
);

    localparam int                  STARVE_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    arb_state_t          state_r;
    arb_state_t          state_nxt_s;
    logic [STARVE_W-1:0] starve_cnt_r;
    logic [STARVE_W-1:0] starve_cnt_nxt_s;
    logic [1:0]          rd_pipe_r;
    logic                conflict_s;
    logic                eng_grant_s;
    logic                host_grant_s;

    assign conflict_s    = eng_req_valid && host_wr_valid;
    // Grants are masked during reset so every output reads zero while reset_n is low.
    assign eng_req_ready = eng_grant_s && reset_n;
    assign host_wr_ready = host_grant_s && reset_n;

    // Grant selection: engine wins conflicts only while streaming and the host is not starved.
    always_comb begin
        eng_grant_s  = 1'b0;
        host_grant_s = 1'b0;
        if (conflict_s) begin
            if ((state_r == ARB_STREAM) && (starve_cnt_r != STARVE_MAX)) begin
                eng_grant_s = 1'b1;
            end else begin
                host_grant_s = 1'b1;
            end
        end else begin
            eng_grant_s  = eng_req_valid;
            host_grant_s = host_wr_valid;
        end
    end

    // Starvation counter: counts lost host cycles, saturating, cleared on a host grant.
    always_comb begin
        starve_cnt_nxt_s = starve_cnt_r;
        if (host_grant_s) begin
            starve_cnt_nxt_s = {STARVE_W{1'b0}};
        end else if (host_wr_valid && (starve_cnt_r != STARVE_MAX)) begin
            starve_cnt_nxt_s = starve_cnt_r + STARVE_W'(1);
        end else begin
            starve_cnt_nxt_s = starve_cnt_r;
        end
    end

    // Next-state logic for the streaming mode FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ARB_IDLE: begin
                if (frame_active) begin
                    state_nxt_s = ARB_STREAM;
                end else begin
                    state_nxt_s = ARB_IDLE;
                end
            end
            ARB_STREAM: begin
                if (!frame_active) begin
                    state_nxt_s = ARB_DRAIN;
                end else begin
                    state_nxt_s = ARB_STREAM;
                end
            end
            ARB_DRAIN: begin
                if (frame_active) begin
                    state_nxt_s = ARB_STREAM;
                end else if (rd_pipe_r == 2'b00) begin
                    state_nxt_s = ARB_IDLE;
                end else begin
                    state_nxt_s = ARB_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ARB_IDLE;
            end
        endcase
    end

    // State, starvation count and read-valid pipe registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ARB_IDLE;
            starve_cnt_r <= {STARVE_W{1'b0}};
            rd_pipe_r    <= 2'b00;
        end else begin
            state_r      <= state_nxt_s;
            starve_cnt_r <= starve_cnt_nxt_s;
            rd_pipe_r    <= {rd_pipe_r[0], eng_grant_s};
        end
    end

    // SRAM drive registers: one transaction per cycle, addresses hold when idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sram_addr_a <= {ADDR_W{1'b0}};
            sram_addr_b <= {ADDR_W{1'b0}};
            sram_we_a   <= 1'b0;
            sram_we_b   <= 1'b0;
            sram_din_a  <= {DATA_W{1'b0}};
            sram_din_b  <= {DATA_W{1'b0}};
        end else begin
            sram_we_a <= 1'b0;
            sram_we_b <= 1'b0;
            if (host_grant_s) begin
                if (bank_hits_a(host_wr_bank)) begin
                    sram_addr_a <= host_wr_addr;
                    sram_din_a  <= host_wr_data;
                    sram_we_a   <= 1'b1;
                end
                if (bank_hits_b(host_wr_bank)) begin
                    sram_addr_b <= host_wr_addr;
                    sram_din_b  <= host_wr_data;
                    sram_we_b   <= 1'b1;
                end
            end else if (eng_grant_s) begin
                sram_addr_a <= eng_req_addr;
                sram_addr_b <= eng_req_addr;
            end
        end
    end

    // Read data arrives from the SRAM one cycle after the registered address.
    assign eng_rsp_valid  = rd_pipe_r[1];
    assign eng_rsp_weight = rd_pipe_r[1] ? sram_dout_a : {DATA_W{1'b0}};
    assign eng_rsp_input  = rd_pipe_r[1] ? sram_dout_b : {DATA_W{1'b0}};

`ifdef ARB_STATS_EN
    logic forced_s;

    assign forced_s = conflict_s && (state_r == ARB_STREAM) && (starve_cnt_r == STARVE_MAX);

    fabric_stat_counter #(.CNT_W(CNT_W)) u_conflicts (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (conflict_s),
        .count   (stat_conflicts)
    );

    fabric_stat_counter #(.CNT_W(CNT_W)) u_forced (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (forced_s),
        .count   (stat_forced)
    );
`else
    assign stat_conflicts = {CNT_W{1'b0}};
    assign stat_forced    = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_fabric_sram_arbiter.sv
// Self-checking bench for fabric_sram_arbiter: directed scenarios plus randomized traffic
// checked against an SRAM content model, a response scoreboard and a grant-rule model.
module tb_fabric_sram_arbiter;
    import fabric_arb_pkg::*;

    localparam int ADDR_W       = 12;
    localparam int DATA_W       = 24;
    localparam int STARVE_LIMIT = 8;
    localparam int CNT_W        = 32;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              frame_active = 1'b0;
    logic              eng_req_valid = 1'b0;
    logic              eng_req_ready;
    logic [ADDR_W-1:0] eng_req_addr = '0;
    logic              eng_rsp_valid;
    logic [DATA_W-1:0] eng_rsp_weight, eng_rsp_input;
    logic              host_wr_valid = 1'b0;
    logic              host_wr_ready;
    logic [ADDR_W-1:0] host_wr_addr = '0;
    logic [1:0]        host_wr_bank = 2'b00;
    logic [DATA_W-1:0] host_wr_data = '0;
    logic [ADDR_W-1:0] sram_addr_a, sram_addr_b;
    logic              sram_we_a, sram_we_b;
    logic [DATA_W-1:0] sram_din_a, sram_din_b;
    logic [DATA_W-1:0] sram_dout_a, sram_dout_b;
    logic [CNT_W-1:0]  stat_conflicts, stat_forced;

    fabric_sram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .frame_active(frame_active),
        .eng_req_valid(eng_req_valid), .eng_req_ready(eng_req_ready), .eng_req_addr(eng_req_addr),
        .eng_rsp_valid(eng_rsp_valid), .eng_rsp_weight(eng_rsp_weight), .eng_rsp_input(eng_rsp_input),
        .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready), .host_wr_addr(host_wr_addr),
        .host_wr_bank(host_wr_bank), .host_wr_data(host_wr_data),
        .sram_addr_a(sram_addr_a), .sram_addr_b(sram_addr_b),
        .sram_we_a(sram_we_a), .sram_we_b(sram_we_b),
        .sram_din_a(sram_din_a), .sram_din_b(sram_din_b),
        .sram_dout_a(sram_dout_a), .sram_dout_b(sram_dout_b),
        .stat_conflicts(stat_conflicts), .stat_forced(stat_forced)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read SRAM with one cycle of read latency.
    logic [DATA_W-1:0] mem_a [0:4095];
    logic [DATA_W-1:0] mem_b [0:4095];
    always @(posedge clk) begin
        if (sram_we_a) mem_a[sram_addr_a] <= sram_din_a;
        if (sram_we_b) mem_b[sram_addr_b] <= sram_din_b;
        sram_dout_a <= mem_a[sram_addr_a];
        sram_dout_b <= mem_b[sram_addr_b];
    end

    // Reference contents updated in transfer order, and expected responses.
    logic [DATA_W-1:0] ref_a [0:4095];
    logic [DATA_W-1:0] ref_b [0:4095];
    typedef struct { int due; logic [DATA_W-1:0] w; logic [DATA_W-1:0] d; } rsp_t;
    rsp_t exp_q[$];
    rsp_t head;

    int checks = 0;
    int errors = 0;
    int exp_conf = 0;
    int exp_forced = 0;

    // Scoreboard: every accepted read returns the latest written data exactly two cycles later.
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            exp_conf = 0;
            exp_forced = 0;
        end else begin
            checks++;
            if (eng_req_ready && host_wr_ready) begin
                errors++;
                $display("FAIL one_ready cyc=%0d eng_ready=%0b host_ready=%0b want at most one", cyc, eng_req_ready, host_wr_ready);
            end
            if (eng_rsp_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_rsp cyc=%0d got valid with no read outstanding", cyc);
                end else begin
                    head = exp_q.pop_front();
                    if (head.due !== cyc || eng_rsp_weight !== head.w || eng_rsp_input !== head.d) begin
                        errors++;
                        $display("FAIL rsp_data cyc=%0d got w=%h i=%h want cyc=%0d w=%h i=%h",
                                 cyc, eng_rsp_weight, eng_rsp_input, head.due, head.w, head.d);
                    end
                end
            end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_rsp cyc=%0d got no valid want response due at %0d", cyc, exp_q[0].due);
                void'(exp_q.pop_front());
            end
            if (eng_req_valid && eng_req_ready)
                exp_q.push_back('{cyc + 2, ref_a[eng_req_addr], ref_b[eng_req_addr]});
            if (host_wr_valid && host_wr_ready) begin
                if (host_wr_bank[0]) ref_a[host_wr_addr] = host_wr_data;
                if (host_wr_bank[1]) ref_b[host_wr_addr] = host_wr_data;
            end
            if (eng_req_valid && host_wr_valid) exp_conf++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_host_write(input logic [ADDR_W-1:0] a, input logic [1:0] b, input logic [DATA_W-1:0] d);
        bit ok = 1'b0;
        host_wr_valid = 1'b1; host_wr_addr = a; host_wr_bank = b; host_wr_data = d;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (host_wr_ready) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL host_wr_timeout got no ready want ready within 40 cycles"); end
        tick();
        host_wr_valid = 1'b0;
    endtask

    task automatic do_eng_read(input logic [ADDR_W-1:0] a, output int hs);
        bit ok = 1'b0;
        hs = -1;
        eng_req_valid = 1'b1; eng_req_addr = a;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (eng_req_ready) begin ok = 1'b1; hs = cyc; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL eng_rd_timeout got no ready want ready within 40 cycles"); end
        tick();
        eng_req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ((|{eng_req_ready, host_wr_ready, eng_rsp_valid, eng_rsp_weight, eng_rsp_input, sram_addr_a, sram_addr_b,
               sram_we_a, sram_we_b, sram_din_a, sram_din_b, stat_conflicts, stat_forced}) !== 1'b0) begin
            errors++; $display("FAIL reset_outputs got nonzero output want all zero in reset");
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ((|{eng_rsp_valid, sram_we_a, sram_we_b, sram_addr_a, sram_addr_b, stat_conflicts, stat_forced}) !== 1'b0) begin
            errors++; $display("FAIL post_reset got nonzero output want idle zero after release");
        end
        tick();
    endtask

    task automatic test_starvation();
        logic [1:0] got;
        logic [1:0] want;
        logic [CNT_W-1:0] want_c, want_f;
        frame_active = 1'b1;
        tick();
        eng_req_valid = 1'b1; eng_req_addr = 12'h020;
        host_wr_valid = 1'b1; host_wr_addr = 12'h040; host_wr_bank = BANK_AB; host_wr_data = 24'h123456;
        for (int i = 0; i <= STARVE_LIMIT; i++) begin
            @(negedge clk);
            got  = {eng_req_ready, host_wr_ready};
            want = (i < STARVE_LIMIT) ? 2'b10 : 2'b01;
            checks++;
            if (got !== want) begin
                errors++; $display("FAIL starve_grant i=%0d got eng/host=%b want %b", i, got, want);
            end
            if (i == STARVE_LIMIT) exp_forced++;
            tick();
            eng_req_addr = 12'h021 + 12'(i);
            if (i == STARVE_LIMIT) begin eng_req_valid = 1'b0; host_wr_valid = 1'b0; end
        end
        @(negedge clk);
`ifdef ARB_STATS_EN
        want_c = 32'd9; want_f = 32'd1;
`else
        want_c = 32'd0; want_f = 32'd0;
`endif
        checks++;
        if (stat_conflicts !== want_c || stat_forced !== want_f) begin
            errors++; $display("FAIL starve_stats got conf=%0d forced=%0d want conf=%0d forced=%0d",
                               stat_conflicts, stat_forced, want_c, want_f);
        end
        tick();
    endtask

    task automatic test_raw_broadcast();
        int h;
        frame_active = 1'b0;
        repeat (6) tick();
        do_host_write(12'h005, BANK_AB, 24'hABCDEF);
        @(negedge clk);
        checks++;
        if ({sram_we_a, sram_we_b} !== 2'b11 || sram_addr_a !== 12'h005 || sram_addr_b !== 12'h005 ||
            sram_din_a !== 24'hABCDEF || sram_din_b !== 24'hABCDEF) begin
            errors++; $display("FAIL bcast_drive got we=%b a=%h/%h din=%h/%h want we=11 a=005 din=abcdef",
                               {sram_we_a, sram_we_b}, sram_addr_a, sram_addr_b, sram_din_a, sram_din_b);
        end
        tick();
        do_eng_read(12'h005, h);
        @(negedge clk);
        checks++;
        if (eng_rsp_valid !== 1'b0) begin errors++; $display("FAIL rsp_early got valid=1 want 0 one cycle after handshake"); end
        @(negedge clk);
        checks++;
        if (eng_rsp_valid !== 1'b1 || eng_rsp_weight !== 24'hABCDEF || eng_rsp_input !== 24'hABCDEF) begin
            errors++; $display("FAIL raw_read got v=%b w=%h i=%h want v=1 w=abcdef i=abcdef",
                               eng_rsp_valid, eng_rsp_weight, eng_rsp_input);
        end
        tick();
    endtask

    task automatic test_idle_priority();
        frame_active = 1'b0;
        repeat (6) tick();
        eng_req_valid = 1'b1; eng_req_addr = 12'h040;
        host_wr_valid = 1'b1; host_wr_addr = 12'h050; host_wr_bank = BANK_A; host_wr_data = 24'h5A5A5A;
        @(negedge clk);
        checks++;
        if ({eng_req_ready, host_wr_ready} !== 2'b01) begin
            errors++; $display("FAIL idle_first got eng/host=%b want 01", {eng_req_ready, host_wr_ready});
        end
        tick();
        host_wr_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({eng_req_ready, host_wr_ready} !== 2'b10) begin
            errors++; $display("FAIL idle_second got eng/host=%b want 10", {eng_req_ready, host_wr_ready});
        end
        tick();
        eng_req_valid = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_bank_select();
        do_host_write(12'h030, BANK_A, 24'h111111);
        @(negedge clk);
        checks++;
        if ({sram_we_a, sram_we_b} !== 2'b10 || sram_addr_a !== 12'h030 || sram_din_a !== 24'h111111) begin
            errors++; $display("FAIL bank_a got we=%b a=%h din=%h want we=10 a=030 din=111111",
                               {sram_we_a, sram_we_b}, sram_addr_a, sram_din_a);
        end
        tick();
        do_host_write(12'h031, 2'b00, 24'h222222);
        @(negedge clk);
        checks++;
        if ({sram_we_a, sram_we_b} !== 2'b00 || sram_addr_a !== 12'h030) begin
            errors++; $display("FAIL bank_none got we=%b a=%h want we=00 a=030", {sram_we_a, sram_we_b}, sram_addr_a);
        end
        tick();
        do_host_write(12'h032, BANK_B, 24'h333333);
        @(negedge clk);
        checks++;
        if ({sram_we_a, sram_we_b} !== 2'b01 || sram_addr_a !== 12'h030 || sram_addr_b !== 12'h032 ||
            sram_din_b !== 24'h333333) begin
            errors++; $display("FAIL bank_b got we=%b a=%h b=%h din=%h want we=01 a=030 b=032 din=333333",
                               {sram_we_a, sram_we_b}, sram_addr_a, sram_addr_b, sram_din_b);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        frame_active = 1'b1;
        tick();
        eng_req_valid = 1'b1; eng_req_addr = 12'h010;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (eng_req_ready !== (i < 4) || eng_rsp_valid !== (i >= 2 && i <= 5)) begin
                errors++; $display("FAIL b2b i=%0d got ready=%b rsp=%b want ready=%b rsp=%b",
                                   i, eng_req_ready, eng_rsp_valid, (i < 4), (i >= 2 && i <= 5));
            end
            if (i == 5) begin
                checks++;
                if (dut.state_r !== ARB_DRAIN) begin
                    errors++; $display("FAIL b2b_drain got state=%0d want %0d", dut.state_r, ARB_DRAIN);
                end
            end
            tick();
            if (i < 3) eng_req_addr = 12'h011 + 12'(i);
            if (i == 3) begin eng_req_valid = 1'b0; frame_active = 1'b0; end
        end
        @(negedge clk);
        checks++;
        if (dut.state_r !== ARB_IDLE || eng_rsp_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_idle got state=%0d rsp=%b want state=%0d rsp=0", dut.state_r, eng_rsp_valid, ARB_IDLE);
        end
        tick();
    endtask

    task automatic test_reset_in_flight();
        int h;
        frame_active = 1'b0;
        repeat (4) tick();
        do_eng_read(12'h077, h);
        reset_n = 1'b0;
        #1;
        checks++;
        if ((|{eng_rsp_valid, eng_rsp_weight, eng_rsp_input, sram_addr_a, sram_addr_b, sram_we_a, sram_we_b,
               eng_req_ready, host_wr_ready, stat_conflicts, stat_forced}) !== 1'b0) begin
            errors++; $display("FAIL reset_async got nonzero output want all zero at once (addr_a=%h)", sram_addr_a);
        end
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (eng_rsp_valid !== 1'b0) begin
                errors++; $display("FAIL reset_drop i=%0d got rsp_valid=1 want 0", i);
            end
        end
        tick();
    endtask

    task automatic test_random(input bit stream, input int n);
        int starve_m = 0;
        bit want_e, want_h, got_e, got_h;
        frame_active = stream;
        repeat (6) tick();
        for (int i = 0; i < n + 24; i++) begin
            @(negedge clk);
            if (eng_req_valid && host_wr_valid) begin
                want_h = !stream || (starve_m == STARVE_LIMIT);
                want_e = !want_h;
            end else begin
                want_e = eng_req_valid;
                want_h = host_wr_valid;
            end
            got_e = eng_req_ready;
            got_h = host_wr_ready;
            checks++;
            if (got_e !== want_e || got_h !== want_h) begin
                errors++; $display("FAIL rand_grant mode=%0d i=%0d starve=%0d got eng/host=%b%b want %b%b",
                                   stream, i, starve_m, got_e, got_h, want_e, want_h);
            end
            if (stream && want_h && eng_req_valid) exp_forced++;
            if (want_h) starve_m = 0;
            else if (host_wr_valid && starve_m < STARVE_LIMIT) starve_m++;
            tick();
            if (eng_req_valid && got_e) eng_req_valid = 1'b0;
            if (host_wr_valid && got_h) host_wr_valid = 1'b0;
            if (!eng_req_valid && i < n && $urandom_range(0, 3) != 0) begin
                eng_req_valid = 1'b1;
                eng_req_addr  = 12'($urandom_range(0, 15));
            end
            if (!host_wr_valid && i < n && $urandom_range(0, 2) != 0) begin
                host_wr_valid = 1'b1;
                host_wr_addr  = 12'($urandom_range(0, 15));
                host_wr_bank  = 2'($urandom_range(0, 3));
                host_wr_data  = 24'($urandom);
            end
        end
        checks++;
        if (eng_req_valid || host_wr_valid) begin
            errors++; $display("FAIL rand_drain got eng=%b host=%b still pending want both served", eng_req_valid, host_wr_valid);
        end
        eng_req_valid = 1'b0;
        host_wr_valid = 1'b0;
        tick();
    endtask

    task automatic test_stats_final();
        logic [CNT_W-1:0] want_c, want_f;
        @(negedge clk);
`ifdef ARB_STATS_EN
        want_c = CNT_W'(exp_conf); want_f = CNT_W'(exp_forced);
`else
        want_c = 32'd0; want_f = 32'd0;
`endif
        checks++;
        if (stat_conflicts !== want_c || stat_forced !== want_f) begin
            errors++; $display("FAIL final_stats got conf=%0d forced=%0d want conf=%0d forced=%0d",
                               stat_conflicts, stat_forced, want_c, want_f);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem_a[i] = '0; mem_b[i] = '0; ref_a[i] = '0; ref_b[i] = '0;
        end
        test_reset();
        test_starvation();
        test_raw_broadcast();
        test_idle_priority();
        test_bank_select();
        test_back_to_back();
        test_reset_in_flight();
        test_random(1'b1, 300);
        test_random(1'b0, 300);
        test_stats_final();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
